// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, syncs, active/border flags and
// a scan-doubled framebuffer row counter with per-frame scroll preload.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 576,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 38,
  parameter int V_BORDER  = 32,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int SCROLL_W  = 8,
  parameter int DBL_SHIFT = 1,
  parameter int CW        = 11
) (
  input  logic                          clk24,
  input  logic                          reset,
  input  logic                          ce,
  input  logic [SCROLL_W-1:0]           scroll,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          video_active,
  output logic                          bordery,
  output logic                          retrace,
  output logic                          line_start,
  output logic                          frame_start,
  output logic [CW-1:0]                 xpos,
  output logic [CW-1:0]                 ypos,
  output logic [SCROLL_W+DBL_SHIFT-1:0] fb_row,
  output logic [SCROLL_W+DBL_SHIFT-1:0] fb_row_count
);

  localparam int FW      = SCROLL_W + DBL_SHIFT;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HLAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS0   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] VBT   = CW'(V_BORDER);
  localparam logic [CW-1:0] VBB   = CW'(V_ACTIVE - V_BORDER);

  // started=0 means the next ce presents (0,0) instead of advancing
  logic          started;
  logic [CW-1:0] nx, ny;
  logic          n_hs, n_vs, n_ls;
  logic [FW-1:0] fb_load;

  always_comb begin
    nx = '0;
    ny = '0;
    if (started) begin
      if (xpos == HLAST) begin
        nx = '0;
        ny = (ypos == VLAST) ? '0 : ypos + CW'(1);
      end else begin
        nx = xpos + CW'(1);
        ny = ypos;
      end
    end
  end

  assign n_hs = (nx >= HS0) && (nx < HS1);
  assign n_vs = (ny >= VS0) && (ny < VS1);
  assign n_ls = (nx == '0);
  assign fb_load = (FW'(scroll) << DBL_SHIFT)
                 | FW'((1 << DBL_SHIFT) - 1);

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      started      <= 1'b0;
      xpos         <= '0;
      ypos         <= '0;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      video_active <= 1'b0;
      bordery      <= 1'b0;
      retrace      <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      fb_row       <= '0;
      fb_row_count <= '0;
    end else if (ce) begin
      started      <= 1'b1;
      xpos         <= nx;
      ypos         <= ny;
      hsync        <= n_hs ? HS_POL : ~HS_POL;
      vsync        <= n_vs ? VS_POL : ~VS_POL;
      video_active <= (nx < HACT) && (ny < VACT);
      bordery      <= ((ny < VBT) || (ny >= VBB)) && (ny < VACT);
      retrace      <= (ny >= VACT);
      line_start   <= n_ls;
      frame_start  <= n_ls && (ny == '0);
      if (n_ls) begin
        if (ny == VBT) begin
          fb_row       <= fb_load;
          fb_row_count <= '1;
        end else begin
          fb_row <= fb_row - FW'(1);
          if (fb_row_count != '0)
            fb_row_count <= fb_row_count - FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x9 raster, with a second
// active-high sync instance sharing all inputs.
module tb_video_timing_gen;

  logic        clk24 = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [7:0]  scroll = 8'h00;

  logic        hsync, vsync, video_active, bordery, retrace;
  logic        line_start, frame_start;
  logic [10:0] xpos, ypos;
  logic [8:0]  fb_row, fb_row_count;

  logic        hsync1, vsync1, va1, bd1, rt1, ls1, fs1;
  logic [10:0] x1, y1;
  logic [8:0]  fr1, fc1;

  int total = 0;
  int bad = 0;

  logic [10:0] ex, ey;
  logic [8:0]  mfb, mcnt;

  always #5 clk24 = ~clk24;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .V_BORDER(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .SCROLL_W(8), .DBL_SHIFT(1), .CW(11)
  ) u0 (
    .clk24(clk24), .reset(reset), .ce(ce), .scroll(scroll),
    .hsync(hsync), .vsync(vsync), .video_active(video_active),
    .bordery(bordery), .retrace(retrace),
    .line_start(line_start), .frame_start(frame_start),
    .xpos(xpos), .ypos(ypos),
    .fb_row(fb_row), .fb_row_count(fb_row_count)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .V_BORDER(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .SCROLL_W(8), .DBL_SHIFT(1), .CW(11)
  ) u1 (
    .clk24(clk24), .reset(reset), .ce(ce), .scroll(scroll),
    .hsync(hsync1), .vsync(vsync1), .video_active(va1),
    .bordery(bd1), .retrace(rt1),
    .line_start(ls1), .frame_start(fs1),
    .xpos(x1), .ypos(y1),
    .fb_row(fr1), .fb_row_count(fc1)
  );

  function automatic logic [28:0] obs();
    return {hsync, vsync, video_active, bordery, retrace,
            line_start, frame_start, xpos, ypos};
  endfunction

  function automatic logic [28:0] expv();
    logic eh, ev, act, bd, rt, ls, fs;
    eh  = (ex >= 10) && (ex < 12);
    ev  = (ey == 7);
    act = (ex < 8) && (ey < 6);
    bd  = ((ey < 1) || (ey >= 5)) && (ey < 6);
    rt  = (ey >= 6);
    ls  = (ex == 0);
    fs  = ls && (ey == 0);
    return {~eh, ~ev, act, bd, rt, ls, fs, ex, ey};
  endfunction

  task automatic adv();
    @(posedge clk24);
    #1;
    if (ce && !reset) begin
      if (ex == 11'd13) begin
        ex = 0;
        ey = (ey == 11'd8) ? 11'd0 : ey + 11'd1;
      end else begin
        ex = ex + 11'd1;
      end
      if (ex == 0) begin
        if (ey == 11'd1) begin
          mfb  = {scroll, 1'b1};
          mcnt = 9'h1FF;
        end else begin
          mfb = mfb - 9'd1;
          if (mcnt != 0) mcnt = mcnt - 9'd1;
        end
      end
    end
  endtask

  task automatic goto(input logic [10:0] tx, input logic [10:0] ty);
    int n;
    n = 0;
    while (!(ex == tx && ey == ty) && n < 200) begin
      adv();
      n++;
    end
    total++;
    if (xpos !== tx || ypos !== ty) begin
      bad++;
      $display("FAIL goto: got x=%0d y=%0d want x=%0d y=%0d",
               xpos, ypos, tx, ty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce = 1'b1;
    repeat (2) @(posedge clk24);
    #1;
    total++;
    if (obs() !== {1'b1, 1'b1, 5'b0, 11'd0, 11'd0}) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs(),
               {1'b1, 1'b1, 5'b0, 11'd0, 11'd0});
    end
    total++;
    if (fb_row !== 9'd0 || fb_row_count !== 9'd0) begin
      bad++;
      $display("FAIL reset_fb: got %h/%h want 0/0", fb_row, fb_row_count);
    end
    total++;
    if (hsync1 !== 1'b0 || vsync1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_pol1: got %b%b want 00", hsync1, vsync1);
    end
    reset = 1'b0;
    @(posedge clk24);
    #1;
    ex = 0;
    ey = 0;
    mfb = 9'h1FF;
    mcnt = 9'h000;
    total++;
    if (frame_start !== 1'b1 || line_start !== 1'b1 || xpos !== 0
        || ypos !== 0 || video_active !== 1'b1) begin
      bad++;
      $display("FAIL first_ce: got fs=%b ls=%b x=%0d y=%0d va=%b want 1 1 0 0 1",
               frame_start, line_start, xpos, ypos, video_active);
    end
  endtask

  task automatic test_raster();
    logic [8:0] ftab [3];
    logic [8:0] ctab [3];
    int gap;
    ftab = '{9'h001, 9'h000, 9'h1FF};
    ctab = '{9'd511, 9'd510, 9'd509};
    gap = 0;
    for (int i = 0; i < 252; i++) begin
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL raster i=%0d: got %h want %h", i, obs(), expv());
      end
      total++;
      if (fb_row !== mfb || fb_row_count !== mcnt) begin
        bad++;
        $display("FAIL fb i=%0d: got %h/%0d want %h/%0d",
                 i, fb_row, fb_row_count, mfb, mcnt);
      end
      total++;
      if (hsync1 !== ~expv()[28] || vsync1 !== ~expv()[27]) begin
        bad++;
        $display("FAIL pol1 i=%0d: got %b%b want %b%b", i, hsync1, vsync1,
                 ~expv()[28], ~expv()[27]);
      end
      if (i < 126 && ex == 0 && ey >= 1 && ey <= 3) begin
        total++;
        if (fb_row !== ftab[ey-1] || fb_row_count !== ctab[ey-1]) begin
          bad++;
          $display("FAIL fb_wrap y=%0d: got %h/%0d want %h/%0d", ey,
                   fb_row, fb_row_count, ftab[ey-1], ctab[ey-1]);
        end
      end
      if (frame_start === 1'b1 && i > 0) begin
        total++;
        if (gap != 126) begin
          bad++;
          $display("FAIL frame_period: got %0d want 126", gap);
        end
        gap = 0;
      end
      adv();
      gap++;
    end
  endtask

  task automatic test_ce_hold();
    logic [28:0] snap;
    goto(11'd4, 11'd2);
    snap = obs();
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv();
      total++;
      if (obs() !== expv() || fb_row !== mfb) begin
        bad++;
        $display("FAIL ce_hold c=%0d: got %h want %h", i, obs(), snap);
      end
    end
    ce = 1'b1;
    adv();
    total++;
    if (xpos !== 11'd5 || ypos !== 11'd2) begin
      bad++;
      $display("FAIL ce_resume: got x=%0d y=%0d want 5 2", xpos, ypos);
    end
  endtask

  task automatic test_scroll();
    scroll = 8'h10;
    goto(11'd0, 11'd1);
    total++;
    if (fb_row !== 9'h021 || fb_row_count !== 9'd511) begin
      bad++;
      $display("FAIL scroll_load: got %h/%0d want 021/511",
               fb_row, fb_row_count);
    end
    goto(11'd3, 11'd2);
    scroll = 8'h20;
    goto(11'd0, 11'd3);
    total++;
    if (fb_row !== 9'h01F || fb_row_count !== 9'd509) begin
      bad++;
      $display("FAIL scroll_mid: got %h/%0d want 01F/509",
               fb_row, fb_row_count);
    end
    goto(11'd0, 11'd0);
    goto(11'd0, 11'd1);
    total++;
    if (fb_row !== 9'h041 || fb_row_count !== 9'd511) begin
      bad++;
      $display("FAIL scroll_next: got %h/%0d want 041/511",
               fb_row, fb_row_count);
    end
  endtask

  task automatic test_reset_mid();
    goto(11'd5, 11'd3);
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== {1'b1, 1'b1, 5'b0, 11'd0, 11'd0} || fb_row !== 9'd0) begin
      bad++;
      $display("FAIL reset_async: got %h fb=%h want %h fb=000", obs(),
               fb_row, {1'b1, 1'b1, 5'b0, 11'd0, 11'd0});
    end
    repeat (2) adv();
    total++;
    if (xpos !== 0 || ypos !== 0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got x=%0d y=%0d fs=%b want 0 0 0",
               xpos, ypos, frame_start);
    end
    reset = 1'b0;
    @(posedge clk24);
    #1;
    ex = 0;
    ey = 0;
    mfb = 9'h1FF;
    mcnt = 9'h000;
    total++;
    if (obs() !== expv() || frame_start !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart: got %h want %h", obs(), expv());
    end
    total++;
    if (fb_row !== mfb || fb_row_count !== mcnt) begin
      bad++;
      $display("FAIL reset_fb_restart: got %h/%0d want 1ff/0",
               fb_row, fb_row_count);
    end
    adv();
    total++;
    if (xpos !== 11'd1 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_step: got x=%0d fs=%b want 1 0", xpos, frame_start);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ex = 0;
    ey = 0;
    mfb = 0;
    mcnt = 0;
    test_reset();
    test_raster();
    test_ce_hold();
    test_scroll();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
